decode: RTL and testbench

DECODE -- requirements
Module: decode

---
 rtl/decode.sv | 62 ++++++
 tb/tb_decode.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/decode.sv
// Decode-stage register file: two combinational read ports and one write port.
// Define DECODE_BYPASS_EN to forward same-cycle write data to matching read ports.
module decode #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWrite,
  input  logic             memReg,
  input  logic             RegDst,
  input  logic [DEPTH-1:0] Reg1,
  input  logic [DEPTH-1:0] Reg2,
  input  logic [15:0]      Inmediate,
  input  logic [WIDTH-1:0] ALUres,
  input  logic [WIDTH-1:0] RData,
  output logic [WIDTH-1:0] RD1,
  output logic [WIDTH-1:0] RD2
);

  localparam int NUMREGS = 2 ** DEPTH;

  logic [WIDTH-1:0] regs [NUMREGS];
  logic [4:0]       rdField;
  logic [DEPTH-1:0] rdAddr;
  logic [DEPTH-1:0] wAddr;
  logic [WIDTH-1:0] wData;
  logic             wEn;
  logic             unusedImm;

  // The rd field is always 5 bits wide; the cast zero-extends or truncates it to DEPTH.
  assign rdField   = Inmediate[15:11];
  assign rdAddr    = DEPTH'(rdField);
  assign unusedImm = ^Inmediate[10:0];

  assign wAddr = RegDst ? rdAddr : Reg2;
  assign wData = memReg ? RData : ALUres;
  assign wEn   = RegWrite && !rst && (wAddr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUMREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wEn) begin
      regs[wAddr] <= wData;
    end
  end

  // Register 0 reads as zero even before the first reset clears the array.
  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if (Reg1 != '0) RD1 = regs[Reg1];
    if (Reg2 != '0) RD2 = regs[Reg2];
`ifdef DECODE_BYPASS_EN
    if (wEn && (Reg1 == wAddr)) RD1 = wData;
    if (wEn && (Reg2 == wAddr)) RD2 = wData;
`endif
  end

endmodule

// File: tb/tb_decode.sv
// Randomized self-checking bench for decode against an array-based register model.
module tb_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite;
  logic        memReg;
  logic        RegDst;
  logic [4:0]  Reg1;
  logic [4:0]  Reg2;
  logic [15:0] Inmediate;
  logic [31:0] ALUres;
  logic [31:0] RData;
  logic [31:0] RD1;
  logic [31:0] RD2;

  int errors = 0;
  int checks = 0;
  logic [31:0] model [32];

`ifdef DECODE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  decode #(.WIDTH(32), .DEPTH(5)) dut (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .memReg(memReg), .RegDst(RegDst),
    .Reg1(Reg1), .Reg2(Reg2), .Inmediate(Inmediate), .ALUres(ALUres), .RData(RData),
    .RD1(RD1), .RD2(RD2)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] destAddr();
    return RegDst ? Inmediate[15:11] : Reg2;
  endfunction

  function automatic logic [31:0] destData();
    return memReg ? RData : ALUres;
  endfunction

  function automatic logic [31:0] expRead(input logic [4:0] a);
    if (rst || a == 5'd0) return 32'd0;
    if (BYPASS && RegWrite && a == destAddr()) return destData();
    return model[a];
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  // Commit the model with the inputs present at the edge, then sample 1 ns later.
  task automatic clockStep();
    logic        doWrite;
    logic [4:0]  wa;
    logic [31:0] wd;
    doWrite = !rst && RegWrite && destAddr() != 5'd0;
    wa = destAddr();
    wd = destData();
    @(posedge clk);
    #1;
    if (doWrite) model[wa] = wd;
  endtask

  task automatic idleInputs();
    RegWrite = 1'b0; memReg = 1'b0; RegDst = 1'b0;
    Inmediate = 16'd0; ALUres = 32'd0; RData = 32'd0;
  endtask

  initial begin
    rst = 1'b1;
    idleInputs();
    Reg1 = 5'd5; Reg2 = 5'd31;
    clearModel();
    #1;
    checkVal("reset_rd1", RD1, 32'd0);
    checkVal("reset_rd2", RD2, 32'd0);
    clockStep();
    rst = 1'b0;
    #1;

    RegWrite = 1'b1; RegDst = 1'b0; memReg = 1'b0; Reg2 = 5'd3; ALUres = 32'h1234_5678;
    clockStep();
    RegWrite = 1'b0; Reg1 = 5'd3;
    #1;
    checkVal("alu_write_rt", RD1, 32'h1234_5678);

    RegWrite = 1'b1; RegDst = 1'b1; memReg = 1'b1; Inmediate = 16'h4800;
    RData = 32'hDEAD_BEEF; Reg2 = 5'd3;
    clockStep();
    RegWrite = 1'b0; Reg2 = 5'd9; Reg1 = 5'd3;
    #1;
    checkVal("mem_write_rd", RD2, 32'hDEAD_BEEF);
    checkVal("rd_write_keeps_r3", RD1, 32'h1234_5678);

    RegWrite = 1'b1; RegDst = 1'b0; memReg = 1'b0; Reg2 = 5'd0; ALUres = 32'hFFFF_FFFF;
    #1;
    checkVal("r0_no_bypass", RD2, 32'd0);
    clockStep();
    RegWrite = 1'b0; Reg1 = 5'd0;
    #1;
    checkVal("r0_reads_zero", RD1, 32'd0);

    RegWrite = 1'b0; Reg2 = 5'd3; ALUres = 32'hAAAA_AAAA;
    clockStep();
    Reg1 = 5'd3;
    #1;
    checkVal("write_disabled", RD1, 32'h1234_5678);

    Reg1 = 5'd4; Reg2 = 5'd4; RegWrite = 1'b1; RegDst = 1'b0; memReg = 1'b0; ALUres = 32'd7;
    #1;
    checkVal("same_cycle_pre_rd1", RD1, BYPASS ? 32'd7 : 32'd0);
    checkVal("same_cycle_pre_rd2", RD2, BYPASS ? 32'd7 : 32'd0);
    clockStep();
    RegWrite = 1'b0;
    #1;
    checkVal("same_cycle_post_rd1", RD1, 32'd7);
    checkVal("same_cycle_post_rd2", RD2, 32'd7);

    // Mid-operation reset clears immediately and blocks writes while held.
    Reg1 = 5'd3; Reg2 = 5'd9;
    #2;
    rst = 1'b1;
    clearModel();
    #1;
    checkVal("async_reset_rd1", RD1, 32'd0);
    checkVal("async_reset_rd2", RD2, 32'd0);
    RegWrite = 1'b1; RegDst = 1'b0; memReg = 1'b0; Reg2 = 5'd6; ALUres = 32'h5555_0001;
    clockStep();
    rst = 1'b0; RegWrite = 1'b0; Reg1 = 5'd6;
    #1;
    checkVal("write_blocked_in_reset", RD1, 32'd0);
    RegWrite = 1'b1; ALUres = 32'h0BAD_F00D;
    clockStep();
    RegWrite = 1'b0;
    #1;
    checkVal("first_write_after_reset", RD1, 32'h0BAD_F00D);

    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 39) == 0);
      RegWrite  = $urandom_range(0, 2) != 0;
      memReg    = 1'($urandom());
      RegDst    = 1'($urandom());
      Inmediate = 16'($urandom());
      ALUres    = $urandom();
      RData     = $urandom();
      Reg2      = 5'($urandom());
      Reg1      = ($urandom_range(0, 3) == 0) ? destAddr() : 5'($urandom());
      if ($urandom_range(0, 7) == 0) Reg2 = Reg1;
      if (rst) clearModel();
      #1;
      checkVal($sformatf("rand_rd1_%0d", n), RD1, expRead(Reg1));
      checkVal($sformatf("rand_rd2_%0d", n), RD2, expRead(Reg2));
      clockStep();
      rst = 1'b0;
      RegWrite = 1'b0;
      #1;
    end

    for (int a = 0; a < 32; a++) begin
      Reg1 = 5'(a); Reg2 = 5'(31 - a);
      #1;
      checkVal($sformatf("final_rd1_%0d", a), RD1, expRead(Reg1));
      checkVal($sformatf("final_rd2_%0d", a), RD2, expRead(Reg2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
